// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        EXEC     = 3'd2,
        MEM_WAIT = 3'd3,
        INJECT   = 3'd4,
        HALT     = 3'd5
    } seq_state_e;

    localparam int              INSTR_W = 16;
    localparam logic [15:0]     PC_INC  = 16'd2;
    localparam logic [15:0]     BR_BASE = 16'd4;

    // Offset is a signed halfword count relative to pc + 4.
    function automatic logic [15:0] branch_target(input logic [15:0] pc, input logic [7:0] off);
        return pc + BR_BASE + {{7{off[7]}}, off, 1'b0};
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes; flags the last allowed cycle.
module seq_timeout_ctr #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count waited cycles, parking at the limit until the owner clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer feeding the control unit. Optional retired-instruction
// counter is built only when INSTR_COUNT_EN is defined.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 64,
    parameter int          COUNT_W     = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               imem_req_o,
    output logic [15:0]        imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               cu_input_en_o,
    input  logic               mem_load_i,
    input  logic               mem_write_i,
    input  logic               branch_i,
    input  logic [7:0]         branch_off_i,
    input  logic               self_instr_en_i,
    input  logic [INSTR_W-1:0] self_instr_i,
    input  logic               end_program_i,
    output logic               dmem_req_o,
    input  logic               dmem_ack_i,
    output logic [15:0]        pc_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic               err_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    seq_state_e         state_r, state_next_s;
    logic [15:0]        pc_r, pc_next_s;
    logic [INSTR_W-1:0] ir_r, ir_next_s;
    logic               inj_r, inj_next_s;
    logic               err_r, err_next_s;
    logic               self_en_r, branch_r;
    logic [7:0]         branch_off_r;
    logic [INSTR_W-1:0] self_instr_r;
    logic               imem_req_r, dmem_req_r, cu_en_r, busy_r, halted_r;

    logic               exec_s, wait_s, ack_s, expired_s;
    logic               self_take_s, branch_take_s;
    logic [7:0]         br_off_s;
    logic [15:0]        adv_pc_s;

    // CU decisions are live in EXEC and replayed from the latches when a data wait ends.
    assign exec_s        = (state_r == EXEC);
    assign self_take_s   = exec_s ? (self_instr_en_i & ~inj_r) : self_en_r;
    assign branch_take_s = exec_s ? (branch_i & ~inj_r) : branch_r;
    assign br_off_s      = exec_s ? branch_off_i : branch_off_r;
    assign adv_pc_s      = branch_take_s ? branch_target(pc_r, br_off_s) : (pc_r + PC_INC);

    assign wait_s = (state_r == FETCH) || (state_r == MEM_WAIT);
    assign ack_s  = ((state_r == FETCH) && imem_ack_i) || ((state_r == MEM_WAIT) && dmem_ack_i);

    seq_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (~wait_s | ack_s),
        .enable  (wait_s),
        .expired (expired_s)
    );

    // Next-state, PC and instruction-register selection.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ir_next_s    = ir_r;
        inj_next_s   = inj_r;
        err_next_s   = err_r;
        case (state_r)
            IDLE, HALT: begin
                if (start_i) begin
                    state_next_s = FETCH;
                    pc_next_s    = RESET_PC;
                    err_next_s   = 1'b0;
                    inj_next_s   = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            FETCH: begin
                if (imem_ack_i) begin
                    ir_next_s    = imem_rdata_i;
                    state_next_s = EXEC;
                end else if (expired_s) begin
                    state_next_s = HALT;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = FETCH;
                end
            end
            EXEC: begin
                if (end_program_i) begin
                    state_next_s = HALT;
                end else if (mem_load_i || mem_write_i) begin
                    state_next_s = MEM_WAIT;
                end else if (self_take_s) begin
                    state_next_s = INJECT;
                end else begin
                    state_next_s = FETCH;
                    pc_next_s    = adv_pc_s;
                    inj_next_s   = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    if (self_take_s) begin
                        state_next_s = INJECT;
                    end else begin
                        state_next_s = FETCH;
                        pc_next_s    = adv_pc_s;
                        inj_next_s   = 1'b0;
                    end
                end else if (expired_s) begin
                    state_next_s = HALT;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = MEM_WAIT;
                end
            end
            INJECT: begin
                ir_next_s    = self_instr_r;
                inj_next_s   = 1'b1;
                state_next_s = EXEC;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath latches and registered outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            ir_r         <= {INSTR_W{1'b0}};
            inj_r        <= 1'b0;
            err_r        <= 1'b0;
            self_en_r    <= 1'b0;
            branch_r     <= 1'b0;
            branch_off_r <= 8'h00;
            self_instr_r <= {INSTR_W{1'b0}};
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            cu_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            ir_r         <= ir_next_s;
            inj_r        <= inj_next_s;
            err_r        <= err_next_s;
            self_en_r    <= self_take_s;
            branch_r     <= branch_take_s;
            branch_off_r <= br_off_s;
            self_instr_r <= exec_s ? self_instr_i : self_instr_r;
            imem_req_r   <= (state_next_s == FETCH);
            dmem_req_r   <= (state_next_s == MEM_WAIT);
            cu_en_r      <= (state_next_s == EXEC);
            busy_r       <= (state_next_s != IDLE) && (state_next_s != HALT);
            halted_r     <= (state_next_s == HALT);
        end
    end

`ifdef INSTR_COUNT_EN
    logic [COUNT_W-1:0] count_r;
    logic               retire_s, count_clr_s;

    // Timeout halts never retire; an end_program halt does.
    assign retire_s    = (exec_s && (end_program_i || !(mem_load_i || mem_write_i))) ||
                         ((state_r == MEM_WAIT) && dmem_ack_i);
    assign count_clr_s = start_i && ((state_r == IDLE) || (state_r == HALT));

    // Saturating retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (count_clr_s) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (retire_s && (count_r != {COUNT_W{1'b1}})) begin
            count_r <= count_r + COUNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign instr_count_o = count_r;
`else
    assign instr_count_o = {COUNT_W{1'b0}};
`endif

    assign imem_req_o    = imem_req_r;
    assign imem_addr_o   = pc_r;
    assign instr_o       = ir_r;
    assign cu_input_en_o = cu_en_r;
    assign dmem_req_o    = dmem_req_r;
    assign pc_o          = pc_r;
    assign busy_o        = busy_r;
    assign halted_o      = halted_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: table of small programs plus hand-written corner sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0, start_i = 1'b0;
    logic        imem_req_o, imem_ack_i = 1'b0;
    logic [15:0] imem_addr_o, imem_rdata_i = 16'h0000;
    logic [15:0] instr_o, self_instr_i = 16'h0000, pc_o;
    logic        cu_input_en_o;
    logic        mem_load_i = 1'b0, mem_write_i = 1'b0, branch_i = 1'b0;
    logic [7:0]  branch_off_i = 8'h00;
    logic        self_instr_en_i = 1'b0, end_program_i = 1'b0;
    logic        dmem_req_o, dmem_ack_i = 1'b0;
    logic        busy_o, halted_o, err_o;
    logic [31:0] instr_count_o;

    instr_sequencer #(.RESET_PC(16'h0000), .MEM_TIMEOUT(64), .COUNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .cu_input_en_o(cu_input_en_o),
        .mem_load_i(mem_load_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
        .branch_off_i(branch_off_i), .self_instr_en_i(self_instr_en_i), .self_instr_i(self_instr_i),
        .end_program_i(end_program_i), .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i),
        .pc_o(pc_o), .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
        .instr_count_o(instr_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] prog;   // {addr, instr} pairs
        logic [7:0]       dlat;
        logic [7:0]       n;
        logic [3:0][15:0] pcs;
        logic [3:0][15:0] ins;
        logic [15:0]      fpc;
        logic [7:0]       dreq;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] mem [logic [15:0]];
    logic [15:0] ex_pc_q[$], ex_ins_q[$];
    int          ireq_n, dreq_n, overlap_n, icnt, dcnt, ilat, dlat;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef INSTR_COUNT_EN
        return 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    task automatic add_vec(input logic [31:0] p0, p1, p2, p3, input int dl, input int n,
                           input logic [15:0] c0, c1, c2, c3, input logic [15:0] i0, i1, i2, i3,
                           input logic [15:0] fpc, input int dr);
        vec_t v;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
        v.dlat = 8'(dl); v.n = 8'(n);
        v.pcs[0] = c0; v.pcs[1] = c1; v.pcs[2] = c2; v.pcs[3] = c3;
        v.ins[0] = i0; v.ins[1] = i1; v.ins[2] = i2; v.ins[3] = i3;
        v.fpc = fpc; v.dreq = 8'(dr);
        vecs.push_back(v);
    endtask

    // One clock: sample outputs after the edge, log them, then drive memory and CU responses.
    task automatic tick();
        @(posedge clk); #1;
        if (imem_req_o) ireq_n++;
        if (dmem_req_o) dreq_n++;
        if (imem_req_o && dmem_req_o) overlap_n++;
        if (cu_input_en_o) begin
            ex_pc_q.push_back(pc_o);
            ex_ins_q.push_back(instr_o);
        end
        if (imem_req_o) begin
            icnt++;
            imem_ack_i   = (icnt == ilat);
            imem_rdata_i = mem_rd(imem_addr_o);
        end else begin
            icnt = 0; imem_ack_i = 1'b0;
        end
        if (dmem_req_o) begin
            dcnt++;
            dmem_ack_i = (dcnt == dlat);
        end else begin
            dcnt = 0; dmem_ack_i = 1'b0;
        end
        end_program_i = 1'b0; mem_load_i = 1'b0; mem_write_i = 1'b0; branch_i = 1'b0;
        self_instr_en_i = 1'b0; self_instr_i = 16'h0000; branch_off_i = 8'h00;
        if (cu_input_en_o) begin
            branch_off_i = instr_o[7:0];
            case (instr_o)
                16'h0000: end_program_i = 1'b1;
                16'hB500: begin self_instr_en_i = 1'b1; self_instr_i = 16'h9701; end
                16'hB5FF: begin self_instr_en_i = 1'b1; self_instr_i = 16'hD0FC; end
                16'hB600: begin self_instr_en_i = 1'b1; self_instr_i = 16'hB500; end
                16'hB401: begin self_instr_en_i = 1'b1; self_instr_i = 16'h2005; mem_load_i = 1'b1; end
                default: begin
                    if (instr_o[15:12] == 4'h6) begin
                        mem_load_i = instr_o[11]; mem_write_i = ~instr_o[11];
                    end else if (instr_o[15:12] == 4'hD) begin
                        branch_i = 1'b1; mem_write_i = instr_o[8];
                    end
                end
            endcase
        end
    endtask

    task automatic clear_logs();
        ex_pc_q.delete(); ex_ins_q.delete();
        ireq_n = 0; dreq_n = 0; overlap_n = 0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int c;
        c = 0;
        while (!halted_o && c < 3000) begin tick(); c++; end
        chk({name, "_halt_reached"}, {31'd0, halted_o}, 32'd1);
    endtask

    task automatic wait_dreq(input string name);
        int c;
        c = 0;
        while (!dmem_req_o && c < 50) begin tick(); c++; end
        chk({name, "_dreq_seen"}, {31'd0, dmem_req_o}, 32'd1);
    endtask

    initial begin
        add_vec(32'h0000_2005, 32'h0002_1C48, 32'h0004_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'h0002, 16'h0004, 16'h0, 16'h2005, 16'h1C48, 16'h0000, 16'h0, 16'h0004, 0);
        add_vec(32'h0000_6808, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 5, 2,
                16'h0000, 16'h0002, 16'h0, 16'h0, 16'h6808, 16'h0000, 16'h0, 16'h0, 16'h0002, 5);
        add_vec(32'h0000_6008, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1, 2,
                16'h0000, 16'h0002, 16'h0, 16'h0, 16'h6008, 16'h0000, 16'h0, 16'h0, 16'h0002, 1);
        add_vec(32'h0000_B500, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'h0000, 16'h0002, 16'h0, 16'hB500, 16'h9701, 16'h0000, 16'h0, 16'h0002, 0);
        add_vec(32'h0000_D0FD, 32'hFFFE_D000, 32'h0002_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'hFFFE, 16'h0002, 16'h0, 16'hD0FD, 16'hD000, 16'h0000, 16'h0, 16'h0002, 0);
        add_vec(32'h0000_D006, 32'h0010_D0FC, 32'h000C_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'h0010, 16'h000C, 16'h0, 16'hD006, 16'hD0FC, 16'h0000, 16'h0, 16'h000C, 0);
        add_vec(32'h0000_B5FF, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'h0000, 16'h0002, 16'h0, 16'hB5FF, 16'hD0FC, 16'h0000, 16'h0, 16'h0002, 0);
        add_vec(32'h0000_B600, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1, 3,
                16'h0000, 16'h0000, 16'h0002, 16'h0, 16'hB600, 16'hB500, 16'h0000, 16'h0, 16'h0002, 0);
        add_vec(32'h0000_B401, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 2, 3,
                16'h0000, 16'h0000, 16'h0002, 16'h0, 16'hB401, 16'h2005, 16'h0000, 16'h0, 16'h0002, 2);
        add_vec(32'h0000_D102, 32'h0008_0000, 32'h0001_0000, 32'h0001_0000, 3, 2,
                16'h0000, 16'h0008, 16'h0, 16'h0, 16'hD102, 16'h0000, 16'h0, 16'h0, 16'h0008, 3);

        icnt = 0; dcnt = 0; ilat = 1; dlat = 1;
        clear_logs();
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; tick();
        chk("rst_imem_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_cu_en", {31'd0, cu_input_en_o}, 32'd0);
        chk("rst_busy_halt_err", {29'd0, busy_o, halted_o, err_o}, 32'd0);
        chk("rst_pc_instr", {pc_o, instr_o}, 32'd0);
        chk("rst_count", instr_count_o, 32'd0);

        for (int v = 0; v < vecs.size(); v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            mem.delete();
            for (int k = 0; k < 4; k++) mem[vecs[v].prog[k][31:16]] = vecs[v].prog[k][15:0];
            ilat = 1; dlat = int'(vecs[v].dlat);
            clear_logs();
            pulse_start();
            run_to_halt(nm);
            chk({nm, "_err"}, {31'd0, err_o}, 32'd0);
            chk({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
            chk({nm, "_n_exec"}, 32'(ex_pc_q.size()), 32'(vecs[v].n));
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                chk($sformatf("%s_pc%0d", nm, k),
                    (k < ex_pc_q.size()) ? {16'h0, ex_pc_q[k]} : 32'hDEAD_0000, {16'h0, vecs[v].pcs[k]});
                chk($sformatf("%s_instr%0d", nm, k),
                    (k < ex_ins_q.size()) ? {16'h0, ex_ins_q[k]} : 32'hDEAD_0000, {16'h0, vecs[v].ins[k]});
            end
            chk({nm, "_final_pc"}, {16'h0, pc_o}, {16'h0, vecs[v].fpc});
            chk({nm, "_dreq_cycles"}, 32'(dreq_n), 32'(vecs[v].dreq));
            chk({nm, "_req_overlap"}, 32'(overlap_n), 32'd0);
            chk({nm, "_count"}, instr_count_o, exp_cnt(int'(vecs[v].n)));
        end

        // Fetch never acknowledged: timeout halt after 64 request cycles.
        mem.delete(); ilat = 0; dlat = 1; clear_logs();
        pulse_start();
        run_to_halt("ito");
        chk("ito_err", {31'd0, err_o}, 32'd1);
        chk("ito_req_cycles", 32'(ireq_n), 32'd64);
        chk("ito_req_dropped", {31'd0, imem_req_o}, 32'd0);
        chk("ito_count", instr_count_o, 32'd0);
        ilat = 1; clear_logs();
        pulse_start();
        chk("ito_restart_err", {31'd0, err_o}, 32'd0);
        chk("ito_restart_fetch", {15'd0, imem_req_o, imem_addr_o}, 32'h0001_0000);
        run_to_halt("ito_restart");
        chk("ito_restart_exec", 32'(ex_pc_q.size()), 32'd1);

        // Ack in the very cycle the timeout would fire: ack wins.
        ilat = 64; clear_logs();
        pulse_start();
        run_to_halt("ack_edge");
        chk("ack_edge_err", {31'd0, err_o}, 32'd0);
        chk("ack_edge_req_cycles", 32'(ireq_n), 32'd64);
        chk("ack_edge_exec", 32'(ex_pc_q.size()), 32'd1);

        // start_i pulsed during a data wait is ignored.
        mem.delete(); mem[16'h0000] = 16'h6808; ilat = 1; dlat = 5; clear_logs();
        pulse_start();
        wait_dreq("busy_start");
        pulse_start();
        run_to_halt("busy_start");
        chk("busy_start_exec", 32'(ex_pc_q.size()), 32'd2);
        chk("busy_start_pc", {16'h0, pc_o}, 32'h0000_0002);
        chk("busy_start_dreq", 32'(dreq_n), 32'd5);

        // Reset mid data wait, then a data-side timeout.
        mem.delete(); mem[16'h0000] = 16'h2005; mem[16'h0002] = 16'h6808; dlat = 0; clear_logs();
        pulse_start();
        wait_dreq("rst_mid");
        chk("rst_mid_pc_before", {16'h0, pc_o}, 32'h0000_0002);
        tick(); tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rst_mid_dreq", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_mid_idle", {30'd0, busy_o, halted_o}, 32'd0);
        chk("rst_mid_pc", {16'h0, pc_o}, 32'h0);
        chk("rst_mid_count", instr_count_o, 32'd0);
        tick();
        chk("rst_mid_stays_idle", {30'd0, busy_o, imem_req_o}, 32'd0);
        clear_logs();
        pulse_start();
        run_to_halt("dto");
        chk("dto_err", {31'd0, err_o}, 32'd1);
        chk("dto_dreq_cycles", 32'(dreq_n), 32'd64);
        chk("dto_pc", {16'h0, pc_o}, 32'h0000_0002);
        chk("dto_count", instr_count_o, exp_cnt(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
